// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used across the memory-side blocks.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
  typedef logic [7:0]  lc3b_byte;
endpackage

// File: rtl/lc3b_byte_bridge_if.sv
// 8-bit req/ack byte bus between the word bridge (master) and byte memory (slave).
interface lc3b_byte_bridge_if;
  import lc3b_types::*;

  logic     bus_req;
  logic     bus_we;
  lc3b_word bus_addr;
  lc3b_byte bus_wdata;
  logic     bus_ack;
  lc3b_byte bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lc3b_byte_bridge.sv
// Serves 16-bit control-unit memory requests as one or two byte transfers on
// an 8-bit req/ack bus, then returns a one-cycle mem_resp with the read word.
module lc3b_byte_bridge
  import lc3b_types::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  lc3b_word            mem_address,
  input  lc3b_word            mem_wdata,
  input  lc3b_mem_wmask       mem_byte_enable,
  output logic                mem_resp,
  output lc3b_word            mem_rdata,
  lc3b_byte_bridge_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t   state_q, state_d;
  lc3b_word addr_q;
  lc3b_word wdata_q;
  logic     hi_en_q;
  logic     op_we_q;
  lc3b_byte rdata_lo_q;
  lc3b_word rdata_q;

  logic req_seen;
  logic bus_done;

  function automatic lc3b_byte lane_of(input lc3b_word w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  assign req_seen = mem_read | mem_write;
  assign bus_done = bus.bus_req & bus.bus_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read) begin
          state_d = S_LO;
        end else if (mem_write) begin
          unique case (mem_byte_enable)
            2'b00:   state_d = S_RESP;
            2'b10:   state_d = S_HI;
            default: state_d = S_LO;
          endcase
        end
      end
      // A low-byte-only write skips the high lane entirely.
      S_LO:    if (bus_done) state_d = (op_we_q && !hi_en_q) ? S_RESP : S_HI;
      S_HI:    if (bus_done) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    mem_resp      = 1'b0;
    unique case (state_q)
      S_LO: begin
        bus.bus_req   = 1'b1;
        bus.bus_we    = op_we_q;
        bus.bus_addr  = addr_q;
        bus.bus_wdata = lane_of(wdata_q, 1'b0);
      end
      S_HI: begin
        bus.bus_req   = 1'b1;
        bus.bus_we    = op_we_q;
        bus.bus_addr  = addr_q | 16'h0001;
        bus.bus_wdata = lane_of(wdata_q, 1'b1);
      end
      S_RESP:  mem_resp = 1'b1;
      default: ;
    endcase
  end

  // Request fields are frozen on acceptance so CPU changes mid-flight are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      hi_en_q <= 1'b0;
      op_we_q <= 1'b0;
    end else if (state_q == S_IDLE && req_seen) begin
      addr_q  <= mem_address & 16'hFFFE;
      wdata_q <= mem_wdata;
      hi_en_q <= mem_byte_enable[1];
      op_we_q <= ~mem_read;
    end
  end

  // The low byte is staged so mem_rdata only changes when a full read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_lo_q <= '0;
      rdata_q    <= '0;
    end else if (bus_done && !op_we_q) begin
      if (state_q == S_LO) rdata_lo_q <= bus.bus_rdata;
      if (state_q == S_HI) rdata_q    <= {bus.bus_rdata, rdata_lo_q};
    end
  end

  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_lc3b_byte_bridge.sv
// Scoreboard bench for lc3b_byte_bridge against a byte memory with programmable ack delay.
module tb_lc3b_byte_bridge;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  lc3b_word      mem_address = '0;
  lc3b_word      mem_wdata = '0;
  lc3b_mem_wmask mem_byte_enable = '0;
  logic          mem_resp;
  lc3b_word      mem_rdata;

  always #5 clk = ~clk;

  lc3b_byte_bridge_if bus();

  lc3b_byte_bridge dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp),
    .mem_rdata(mem_rdata),
    .bus(bus)
  );

  // Byte memory seen by the DUT and an independent reference copy.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  int  wcnt = 0;
  int  wait_tgt = 0;
  int  fixed_wait = 0;
  bit  rnd_mode = 1'b0;

  assign bus.bus_ack   = bus.bus_req && (wcnt >= wait_tgt);
  assign bus.bus_rdata = mem[bus.bus_addr];

  always @(posedge clk) begin
    if (bus.bus_req && bus.bus_ack) begin
      if (bus.bus_we) mem[bus.bus_addr] <= bus.bus_wdata;
      wcnt     <= 0;
      wait_tgt <= rnd_mode ? int'($urandom_range(0, 3)) : fixed_wait;
    end else if (bus.bus_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt     <= 0;
      wait_tgt <= rnd_mode ? int'($urandom_range(0, 3)) : fixed_wait;
    end
  end

  typedef struct {
    bit       is_read;
    lc3b_word data;
  } exp_t;

  exp_t     exp_q[$];
  lc3b_word last_rd = '0;
  int       checks = 0;
  int       errors = 0;

  lc3b_word acc_addr[$];
  lc3b_byte acc_wd[$];
  bit       acc_we[$];
  int       resp_cyc;
  int       nresp;
  lc3b_word resp_data;

  task automatic push_expect(input bit rd, input lc3b_word a, input lc3b_word wd,
                             input lc3b_mem_wmask be);
    exp_t     e;
    lc3b_word lo_a;
    lc3b_word hi_a;
    lo_a = a & 16'hFFFE;
    hi_a = a | 16'h0001;
    e.is_read = rd;
    if (rd) begin
      e.data  = {ref_mem[hi_a], ref_mem[lo_a]};
      last_rd = e.data;
    end else begin
      if (be[0]) ref_mem[lo_a] = wd[7:0];
      if (be[1]) ref_mem[hi_a] = wd[15:8];
      e.data = last_rd;
    end
    exp_q.push_back(e);
  endtask

  // Drives one CPU request and records bus transfers and mem_resp timing.
  task automatic issue(input bit rd, input bit wr, input lc3b_word a, input lc3b_word wd,
                       input lc3b_mem_wmask be, input int drop_cyc);
    acc_addr.delete();
    acc_wd.delete();
    acc_we.delete();
    resp_cyc  = -1;
    nresp     = 0;
    resp_data = '0;
    @(posedge clk);
    #1;
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = a;
    mem_wdata       = wd;
    mem_byte_enable = be;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (bus.bus_req && bus.bus_ack) begin
        acc_addr.push_back(bus.bus_addr);
        acc_wd.push_back(bus.bus_wdata);
        acc_we.push_back(bus.bus_we);
      end
      if (mem_resp) begin
        nresp++;
        if (resp_cyc < 0) begin
          resp_cyc  = cyc;
          resp_data = mem_rdata;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      if (cyc + 1 == drop_cyc) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      if (resp_cyc >= 0 && cyc >= resp_cyc + 2) break;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL rst_mem_resp got %b want 0", mem_resp); end
    checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %b want 0", bus.bus_req); end
    checks++; if (bus.bus_we !== 1'b0) begin errors++; $display("FAIL rst_bus_we got %b want 0", bus.bus_we); end
    checks++; if (bus.bus_addr !== 16'h0000) begin errors++; $display("FAIL rst_bus_addr got %h want 0000", bus.bus_addr); end
    checks++; if (bus.bus_wdata !== 8'h00) begin errors++; $display("FAIL rst_bus_wdata got %h want 00", bus.bus_wdata); end
    checks++; if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL rst_mem_rdata got %h want 0000", mem_rdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL idle_bus_req got %b want 0", bus.bus_req); end
  endtask

  task automatic test_read_zero_wait();
    exp_t e;
    mem[16'h1234] = 8'hCD; ref_mem[16'h1234] = 8'hCD;
    mem[16'h1235] = 8'hAB; ref_mem[16'h1235] = 8'hAB;
    fixed_wait = 0;
    push_expect(1'b1, 16'h1235, 16'h0000, 2'b00);
    issue(1'b1, 1'b0, 16'h1235, 16'h0000, 2'b00, -1);
    e = exp_q.pop_front();
    checks++; if (resp_cyc !== 3) begin errors++; $display("FAIL rd_resp_cycle got %0d want 3", resp_cyc); end
    checks++; if (resp_data !== e.data) begin errors++; $display("FAIL rd_data got %h want %h", resp_data, e.data); end
    checks++; if (resp_data !== 16'hABCD) begin errors++; $display("FAIL rd_data_abcd got %h want abcd", resp_data); end
    checks++; if (acc_addr.size() !== 2) begin errors++; $display("FAIL rd_xfers got %0d want 2", acc_addr.size()); end
    checks++; if (acc_addr[0] !== 16'h1234) begin errors++; $display("FAIL rd_addr0 got %h want 1234", acc_addr[0]); end
    checks++; if (acc_addr[1] !== 16'h1235) begin errors++; $display("FAIL rd_addr1 got %h want 1235", acc_addr[1]); end
    checks++; if (acc_we[0] !== 1'b0) begin errors++; $display("FAIL rd_we got %b want 0", acc_we[0]); end
  endtask

  task automatic test_write_hi_wait();
    exp_t e;
    fixed_wait = 2;
    push_expect(1'b0, 16'h0040, 16'h5A3C, 2'b10);
    issue(1'b0, 1'b1, 16'h0040, 16'h5A3C, 2'b10, -1);
    e = exp_q.pop_front();
    checks++; if (resp_cyc !== 4) begin errors++; $display("FAIL wrhi_resp_cycle got %0d want 4", resp_cyc); end
    checks++; if (resp_data !== e.data) begin errors++; $display("FAIL wrhi_rdata_kept got %h want %h", resp_data, e.data); end
    checks++; if (acc_addr.size() !== 1) begin errors++; $display("FAIL wrhi_xfers got %0d want 1", acc_addr.size()); end
    checks++; if (acc_addr[0] !== 16'h0041) begin errors++; $display("FAIL wrhi_addr got %h want 0041", acc_addr[0]); end
    checks++; if (acc_wd[0] !== 8'h5A) begin errors++; $display("FAIL wrhi_wdata got %h want 5a", acc_wd[0]); end
    checks++; if (acc_we[0] !== 1'b1) begin errors++; $display("FAIL wrhi_we got %b want 1", acc_we[0]); end
    checks++; if (mem[16'h0040] !== ref_mem[16'h0040]) begin errors++; $display("FAIL wrhi_lo_unchanged got %h want %h", mem[16'h0040], ref_mem[16'h0040]); end
    checks++; if (mem[16'h0041] !== 8'h5A) begin errors++; $display("FAIL wrhi_hi_byte got %h want 5a", mem[16'h0041]); end
    fixed_wait = 0;
  endtask

  task automatic test_write_lo();
    exp_t e;
    fixed_wait = 0;
    push_expect(1'b0, 16'h0081, 16'h77EE, 2'b01);
    issue(1'b0, 1'b1, 16'h0081, 16'h77EE, 2'b01, -1);
    e = exp_q.pop_front();
    checks++; if (resp_cyc !== 2) begin errors++; $display("FAIL wrlo_resp_cycle got %0d want 2", resp_cyc); end
    checks++; if (resp_data !== e.data) begin errors++; $display("FAIL wrlo_rdata_kept got %h want %h", resp_data, e.data); end
    checks++; if (acc_addr.size() !== 1) begin errors++; $display("FAIL wrlo_xfers got %0d want 1", acc_addr.size()); end
    checks++; if (acc_addr[0] !== 16'h0080) begin errors++; $display("FAIL wrlo_addr got %h want 0080", acc_addr[0]); end
    checks++; if (acc_wd[0] !== 8'hEE) begin errors++; $display("FAIL wrlo_wdata got %h want ee", acc_wd[0]); end
    checks++; if (mem[16'h0081] !== ref_mem[16'h0081]) begin errors++; $display("FAIL wrlo_hi_unchanged got %h want %h", mem[16'h0081], ref_mem[16'h0081]); end
  endtask

  task automatic test_write_be00();
    exp_t e;
    fixed_wait = 0;
    push_expect(1'b0, 16'h0100, 16'hFFFF, 2'b00);
    issue(1'b0, 1'b1, 16'h0100, 16'hFFFF, 2'b00, -1);
    e = exp_q.pop_front();
    checks++; if (resp_cyc !== 1) begin errors++; $display("FAIL be00_resp_cycle got %0d want 1", resp_cyc); end
    checks++; if (acc_addr.size() !== 0) begin errors++; $display("FAIL be00_xfers got %0d want 0", acc_addr.size()); end
    checks++; if (resp_data !== e.data) begin errors++; $display("FAIL be00_rdata_kept got %h want %h", resp_data, e.data); end
    push_expect(1'b1, 16'h1234, 16'h0000, 2'b00);
    issue(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, -1);
    e = exp_q.pop_front();
    checks++; if (resp_cyc !== 3) begin errors++; $display("FAIL be00_rd_cycle got %0d want 3", resp_cyc); end
    checks++; if (resp_data !== e.data) begin errors++; $display("FAIL be00_rd_data got %h want %h", resp_data, e.data); end
  endtask

  task automatic test_rd_wr_drop();
    exp_t e;
    fixed_wait = 0;
    push_expect(1'b1, 16'h1234, 16'h0000, 2'b11);
    issue(1'b1, 1'b1, 16'h1234, 16'hFFFF, 2'b11, 2);
    e = exp_q.pop_front();
    checks++; if (nresp !== 1) begin errors++; $display("FAIL rdwr_nresp got %0d want 1", nresp); end
    checks++; if (resp_cyc !== 3) begin errors++; $display("FAIL rdwr_resp_cycle got %0d want 3", resp_cyc); end
    checks++; if (resp_data !== e.data) begin errors++; $display("FAIL rdwr_data got %h want %h", resp_data, e.data); end
    checks++; if (acc_addr.size() !== 2) begin errors++; $display("FAIL rdwr_xfers got %0d want 2", acc_addr.size()); end
    checks++; if ((acc_we[0] | acc_we[1]) !== 1'b0) begin errors++; $display("FAIL rdwr_we got %b%b want 00", acc_we[1], acc_we[0]); end
    checks++; if (mem[16'h1234] !== 8'hCD) begin errors++; $display("FAIL rdwr_mem_kept got %h want cd", mem[16'h1234]); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    fixed_wait = 0;
    @(posedge clk);
    #1;
    mem_read    = 1'b1;
    mem_address = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    fixed_wait = 50;
    @(negedge clk);
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 16'h1235) begin errors++; $display("FAIL mid_in_hi got req=%b addr=%h want req=1 addr=1235", bus.bus_req, bus.bus_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop got %b want 0", bus.bus_req); end
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL mid_resp got %b want 0", mem_resp); end
    checks++; if (bus.bus_addr !== 16'h0000 || bus.bus_wdata !== 8'h00 || bus.bus_we !== 1'b0) begin errors++; $display("FAIL mid_bus_out got addr=%h wd=%h we=%b want 0", bus.bus_addr, bus.bus_wdata, bus.bus_we); end
    checks++; if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL mid_rdata got %h want 0000", mem_rdata); end
    mem_read   = 1'b0;
    fixed_wait = 0;
    last_rd    = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_expect(1'b1, 16'h1234, 16'h0000, 2'b00);
    issue(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, -1);
    e = exp_q.pop_front();
    checks++; if (resp_cyc !== 3) begin errors++; $display("FAIL mid_after_cycle got %0d want 3", resp_cyc); end
    checks++; if (resp_data !== e.data) begin errors++; $display("FAIL mid_after_data got %h want %h", resp_data, e.data); end
  endtask

  task automatic test_back_to_back();
    exp_t          e;
    bit            rd;
    lc3b_word      a;
    lc3b_word      wd;
    lc3b_mem_wmask be;
    rnd_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 16'h0100 + 16'($urandom_range(0, 63));
      wd = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      push_expect(rd, a, wd, be);
      issue(rd, !rd, a, wd, be, -1);
      e = exp_q.pop_front();
      checks++; if (resp_cyc < 0) begin errors++; $display("FAIL b2b_timeout txn %0d got no resp want resp", n); end
      checks++; if (nresp !== 1) begin errors++; $display("FAIL b2b_pulse txn %0d got %0d resp cycles want 1", n, nresp); end
      checks++; if (resp_data !== e.data) begin errors++; $display("FAIL b2b_data txn %0d rd=%b got %h want %h", n, rd, resp_data, e.data); end
    end
    rnd_mode = 1'b0;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    test_reset();
    test_read_zero_wait();
    test_write_hi_wait();
    test_write_lo();
    test_write_be00();
    test_rd_wr_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3b_byte_bridge.md
# lc3b_byte_bridge

Memory-side bridge directly downstream of the LC-3b multicycle control unit. It accepts the control unit's 16-bit word requests (`mem_read` / `mem_write`, `mem_byte_enable`, held until `mem_resp`). It serves each request as one or two byte transfers on an 8-bit req/ack memory bus. It then returns a single-cycle `mem_resp` with the assembled 16-bit `mem_rdata`.

## Interface
- No parameters. Address and data widths are fixed by `lc3b_word` (16 bits).
- `clk` — in, 1 — sole clock; all state updates on its rising edge.
- `rst_n` — in, 1 — reset; one clock; reset is asynchronous and active-low.
- `mem_read` — in, 1 — word read request; held by the CPU until `mem_resp`.
- `mem_write` — in, 1 — word write request; held by the CPU until `mem_resp`.
- `mem_address` — in, 16 — byte address; bit 0 ignored (word-aligned).
- `mem_wdata` — in, 16 — write data; `[7:0]` is the low byte, `[15:8]` is the high byte.
- `mem_byte_enable` — in, 2 — `lc3b_mem_wmask`; bit 0 is the low byte, bit 1 is the high byte; writes only.
- `mem_resp` — out, 1 — one-cycle completion pulse.
- `mem_rdata` — out, 16 — read word; valid while `mem_resp`=1 and held until the next read completes.
- `bus_req` — out, 1 — byte transfer request.
- `bus_we` — out, 1 — 1 = byte write, 0 = byte read.
- `bus_addr` — out, 16 — byte address of the current transfer.
- `bus_wdata` — out, 8 — byte write data.
- `bus_ack` — in, 1 — transfer done; sampled on rising `clk` while `bus_req`=1.
- `bus_rdata` — in, 8 — read byte; valid when `bus_ack`=1.

## Operation
States are IDLE, LO, HI and RESP.
- **IDLE**
  - Samples `mem_read | mem_write`.
  - On a request, latches the following into internal registers: address (bit 0 cleared), wdata, byte_enable, and op.
  - If both `mem_read` and `mem_write` are high, the read wins.
  - Next state:
    - read → LO
    - write with be=2'b11 or 2'b01 → LO
    - write with be=2'b10 → HI
    - write with be=2'b00 → RESP (no bus activity)
- **LO**
  - Drives `bus_req`=1, `bus_addr`={addr[15:1],1'b0}, `bus_we`=op, `bus_wdata`=wdata[7:0].
  - On `bus_ack`: a read captures `bus_rdata` into rdata[7:0].
  - Next state: HI, except a write with be[1]=0 goes to RESP.
- **HI**
  - Drives `bus_req`=1, `bus_addr`={addr[15:1],1'b1}, `bus_wdata`=wdata[15:8].
  - On `bus_ack`: a read captures into rdata[15:8].
  - Next state: RESP.
- **RESP**
  - `mem_resp`=1 for exactly one cycle; `mem_rdata` = assembled word.
  - Next state: IDLE unconditionally. Requests are not sampled in RESP.
- Reads always transfer both bytes; `mem_byte_enable` is ignored for reads.
- Bus outputs are decoded from state and latched registers. They stay stable for the whole time `bus_req`=1. `bus_req`=0 in IDLE and RESP.
- Once a transaction has left IDLE, it always completes. Deasserting or changing `mem_read`, `mem_write` or `mem_address` mid-transaction has no effect.
- A write does not modify `mem_rdata`.

## Timing
- Reset (async assert, synchronous release):
  - state is IDLE.
  - `mem_resp`, `bus_req` and `bus_we` are 0; `bus_addr` is 16'h0000, `bus_wdata` is 8'h00 and `mem_rdata` is 16'h0000.
  - Latched registers are 0.
  - Asserting reset mid-transaction drops `bus_req` immediately, with no `mem_resp`.
- Zero-wait bus (`bus_ack` high in the same cycle `bus_req` rises), with the request first seen in cycle 0:
  - Two-byte access: LO in cycle 1, HI in cycle 2, `mem_resp` in cycle 3.
  - Single-byte write: `mem_resp` in cycle 2.
  - be=00 write: `mem_resp` in cycle 1.
- Each cycle with `bus_req`=1 and `bus_ack`=0 adds one cycle of latency.
- Between LO and HI, `bus_req` stays high and only `bus_addr` and `bus_wdata` change.
- A request that is still high in the cycle after RESP starts a new transaction. The control FSM never does this, but it must work.
- `bus_ack` while `bus_req`=0 is ignored.

## Structure
- `lc3b_types` already provides `lc3b_word` and `lc3b_mem_wmask`.
- Add `lc3b_byte` (logic [7:0]) to `lc3b_types`.
- The state enum stays local to the module.
- Single module, no sub-modules: byte-lane selection is two muxes, which do not justify a separate block.

## Test plan
- **Read, zero-wait.** Memory holds byte 0x1234 = 8'hCD and 0x1235 = 8'hAB. `mem_read` with address 16'h1235 → `bus_addr` is 0x1234 then 0x1235; `mem_resp` in cycle 3 with `mem_rdata`=16'hABCD.
- **Write, be=2'b10, two wait cycles.** Address 16'h0040, wdata 16'h5A3C → a single bus write: `bus_addr`=0x0041, `bus_wdata`=8'h5A. `mem_resp` in cycle 4. Byte 0x0040 is unchanged.
- **Write, be=2'b00.** → no `bus_req`; `mem_resp` in cycle 1. A following read returns the previous `mem_rdata` unchanged.
- **Simultaneous read and write, request dropped.** `mem_read`=`mem_write`=1, then both drop in cycle 2 → a full read completes with `bus_we`=0 on both bytes and exactly one `mem_resp`.
- **Reset mid-transfer.** `rst_n` pulled low in HI with `bus_ack` held 0 → `bus_req` goes 0 within the same cycle and all outputs reset. After release, a new read works normally.
- **Back-to-back, random ack delays.** 200 random reads and writes against a reference memory model → every `mem_resp` is a one-cycle pulse and read data matches the model.
